// File: rtl/pacman_pkg.sv
// Shared maze definitions for the pacman datapath: pixel codes, maze geometry and
// the dot eraser state encoding.
package pacman_pkg;

  localparam int unsigned MAZE_W_DEFAULT = 228;
  localparam int unsigned MAZE_H_DEFAULT = 144;
  localparam int unsigned DOT_SIZE       = 4;
  localparam int unsigned MAZE_ADDR_W    = 19;
  localparam int unsigned DOT_POINTS     = 10;

  // Code 2'd3 is reserved and behaves like any other non-DOT pixel.
  typedef enum logic [1:0] {
    PixEmpty = 2'd0,
    PixWall  = 2'd1,
    PixDot   = 2'd2
  } pixel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } eraser_state_e;

endpackage

// File: rtl/dot_eraser_if.sv
// Eat-request handshake plus maze RAM read/write ports of the dot eraser.
// The slave modport is the engine; master is game logic together with the RAM.
interface dot_eraser_if;
  import pacman_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [8:0]             req_x;
  logic [8:0]             req_y;
  logic [MAZE_ADDR_W-1:0] ram_rd_addr;
  logic [1:0]             ram_rd_data;
  logic                   ram_we;
  logic [MAZE_ADDR_W-1:0] ram_wr_addr;
  logic [1:0]             ram_wr_data;

  modport master (
    output req_valid, req_x, req_y, ram_rd_data,
    input  req_ready, ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  req_valid, req_x, req_y, ram_rd_data,
    output req_ready, ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data
  );

endinterface

// File: rtl/dot_offset_gen.sv
// Maps a footprint index (row-major, 4x4) to its pixel offset from the footprint's
// top-left corner in a maze of row stride MAZE_W.
module dot_offset_gen
  import pacman_pkg::*;
#(
  parameter int unsigned MAZE_W = MAZE_W_DEFAULT
) (
  input  logic [3:0]             idx,
  output logic [MAZE_ADDR_W-1:0] offset
);

  always_comb begin
    offset = MAZE_ADDR_W'(idx[3:2]) * MAZE_ADDR_W'(MAZE_W) + MAZE_ADDR_W'(idx[1:0]);
  end

endmodule

// File: rtl/dot_eraser.sv
// Read-modify-write engine that clears DOT pixels in a 4x4 footprint of maze RAM.
// Optional score output enabled by defining DOT_ERASER_SCORE_EN.
module dot_eraser
  import pacman_pkg::*;
#(
  parameter int unsigned MAZE_W = MAZE_W_DEFAULT,
  parameter int unsigned MAZE_H = MAZE_H_DEFAULT,
  parameter int unsigned CNT_W  = 9
) (
  input  logic             Clk,
  input  logic             Reset,
  dot_eraser_if.slave      bus,
  output logic             dot_eaten,
  output logic             req_err,
  output logic [CNT_W-1:0] dots_eaten,
  output logic             busy
`ifdef DOT_ERASER_SCORE_EN
  ,
  output logic [15:0]      score
`endif
);

  eraser_state_e          state_q, state_d;
  logic [MAZE_ADDR_W-1:0] base_q, base_d;
  logic [3:0]             idx_q, idx_d;
  logic                   err_q, err_d;
  logic [4:0]             clr_cnt_q, clr_cnt_d;
  logic                   wr_vld_q;
  logic [MAZE_ADDR_W-1:0] wr_addr_q;
  logic [CNT_W-1:0]       dots_eaten_q, dots_eaten_d;

  logic [MAZE_ADDR_W-1:0] offset;
  logic [MAZE_ADDR_W-1:0] rd_addr;
  logic                   rd_en;
  logic                   oob;

  dot_offset_gen #(
    .MAZE_W (MAZE_W)
  ) u_offset (
    .idx    (idx_q),
    .offset (offset)
  );

  assign rd_addr = base_q + offset;

  always_comb begin
    oob = (32'(bus.req_x) + DOT_SIZE - 1 >= MAZE_W) ||
          (32'(bus.req_y) + DOT_SIZE - 1 >= MAZE_H);
  end

  // Write stage: the RAM returns the pixel one cycle after the read, so the
  // decision to clear is taken against the registered read address.
  always_comb begin
    bus.ram_we      = wr_vld_q && (bus.ram_rd_data == PixDot);
    bus.ram_wr_addr = wr_addr_q;
    bus.ram_wr_data = PixEmpty;
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    err_d     = err_q;
    clr_cnt_d = bus.ram_we ? clr_cnt_q + 5'd1 : clr_cnt_q;
    rd_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          base_d    = MAZE_ADDR_W'(bus.req_y) * MAZE_ADDR_W'(MAZE_W) +
                      MAZE_ADDR_W'(bus.req_x);
          idx_d     = 4'd0;
          clr_cnt_d = 5'd0;
          err_d     = oob;
          state_d   = oob ? StDone : StScan;
        end
      end
      StScan: begin
        rd_en = 1'b1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state_q == StIdle);
    busy            = (state_q != StIdle);
    bus.ram_rd_addr = rd_en ? rd_addr : '0;
    dot_eaten       = (state_q == StDone) && (clr_cnt_q != 5'd0) && !err_q;
    req_err         = (state_q == StDone) && err_q;
    dots_eaten_d    = dots_eaten_q;
    if (dot_eaten && (dots_eaten_q != {CNT_W{1'b1}})) begin
      dots_eaten_d = dots_eaten_q + CNT_W'(1);
    end
  end

  assign dots_eaten = dots_eaten_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      base_q       <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      clr_cnt_q    <= '0;
      wr_vld_q     <= 1'b0;
      wr_addr_q    <= '0;
      dots_eaten_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_vld_q     <= rd_en;
      if (rd_en) wr_addr_q <= rd_addr;
      dots_eaten_q <= dots_eaten_d;
    end
  end

`ifdef DOT_ERASER_SCORE_EN
  logic [15:0] score_q, score_d;

  // Score tracks every eaten dot, even once the dot counter has saturated.
  always_comb begin
    score_d = score_q;
    if (dot_eaten) begin
      score_d = (score_q > 16'hFFFF - 16'(DOT_POINTS)) ? 16'hFFFF : score_q + 16'(DOT_POINTS);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_dot_eraser.sv
// Directed self-checking bench for dot_eraser with a behavioural maze RAM
// (registered read, write on ram_we).
module tb_dot_eraser;

  localparam int MW = 228;

  logic        Clk;
  logic        Reset;
  logic        dot_eaten;
  logic        req_err;
  logic [8:0]  dots_eaten;
  logic        busy;
`ifdef DOT_ERASER_SCORE_EN
  logic [15:0] score;
`endif

  dot_eraser_if bus ();

  dot_eraser dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus),
    .dot_eaten  (dot_eaten),
    .req_err    (req_err),
    .dots_eaten (dots_eaten),
    .busy       (busy)
`ifdef DOT_ERASER_SCORE_EN
    ,
    .score      (score)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0] mem [0:524287];

  always @(posedge Clk) begin
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
    if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end

  int total = 0;
  int bad   = 0;
  int wr_q[$];
  int n_eat, n_err, eat_cyc, err_cyc, rdy_cyc, dots_at_rdy;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int x, input int y, input int i);
    return (y + i / 4) * MW + x + i % 4;
  endfunction

  task automatic fill(input int x, input int y, input logic [1:0] code);
    for (int i = 0; i < 16; i++) mem[19'(pix(x, y, i))] = code;
  endtask

  // Issue one request and record events; cycle 1 is the cycle right after the accept edge.
  task automatic run_req(input int x, input int y);
    wr_q.delete();
    n_eat = 0; n_err = 0; eat_cyc = 0; err_cyc = 0; rdy_cyc = 0; dots_at_rdy = -1;
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_x     = 9'(x);
    bus.req_y     = 9'(y);
    @(negedge Clk);
    bus.req_valid = 1'b0;
    bus.req_x     = 9'h1FF;
    bus.req_y     = 9'h1FF;
    for (int c = 1; c <= 40; c++) begin
      if (bus.ram_we) wr_q.push_back(int'(bus.ram_wr_addr));
      if (dot_eaten) begin n_eat++; eat_cyc = c; end
      if (req_err)   begin n_err++; err_cyc = c; end
      if (bus.req_ready) begin
        rdy_cyc     = c;
        dots_at_rdy = int'(dots_eaten);
        break;
      end
      @(negedge Clk);
    end
  endtask

  int exp_full [16] = '{4570, 4571, 4572, 4573, 4798, 4799, 4800, 4801,
                        5026, 5027, 5028, 5029, 5254, 5255, 5256, 5257};
  int n_bad;

  initial begin
    for (int i = 0; i < MW * 144; i++) mem[19'(i)] = 2'd0;
    Reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    chk("rst_ready", int'(bus.req_ready), 1);
    chk("rst_we", int'(bus.ram_we), 0);
    chk("rst_rd_addr", int'(bus.ram_rd_addr), 0);
    chk("rst_wr_addr", int'(bus.ram_wr_addr), 0);
    chk("rst_wr_data", int'(bus.ram_wr_data), 0);
    chk("rst_dot_eaten", int'(dot_eaten), 0);
    chk("rst_req_err", int'(req_err), 0);
    chk("rst_dots_eaten", int'(dots_eaten), 0);
    chk("rst_busy", int'(busy), 0);

    // Full dot at (10,20)
    fill(10, 20, 2'd2);
    run_req(10, 20);
    chk("full_nwr", wr_q.size(), 16);
    n_bad = 0;
    for (int i = 0; i < 16; i++) if (wr_q[i] != exp_full[i]) n_bad++;
    chk("full_addrs_wrong", n_bad, 0);
    chk("full_eat_cyc", eat_cyc, 18);
    chk("full_neat", n_eat, 1);
    chk("full_nerr", n_err, 0);
    chk("full_rdy_cyc", rdy_cyc, 19);
    chk("full_dots", dots_at_rdy, 1);
    n_bad = 0;
    for (int i = 0; i < 16; i++) if (mem[19'(pix(10, 20, i))] != 2'd0) n_bad++;
    chk("full_mem_not_empty", n_bad, 0);

    // All-WALL footprint at (50,50)
    fill(50, 50, 2'd1);
    run_req(50, 50);
    chk("wall_nwr", wr_q.size(), 0);
    chk("wall_neat", n_eat, 0);
    chk("wall_rdy_cyc", rdy_cyc, 19);
    chk("wall_dots", dots_at_rdy, 1);
    n_bad = 0;
    for (int i = 0; i < 16; i++) if (mem[19'(pix(50, 50, i))] != 2'd1) n_bad++;
    chk("wall_mem_changed", n_bad, 0);

    // Partial dot: only idx 5 of (100,60); base 13780, target 14009
    fill(100, 60, 2'd1);
    mem[19'(14009)] = 2'd2;
    mem[19'(pix(100, 60, 10))] = 2'd3;
    run_req(100, 60);
    chk("part_nwr", wr_q.size(), 1);
    chk("part_addr", wr_q[0], 14009);
    chk("part_neat", n_eat, 1);
    chk("part_dots", dots_at_rdy, 2);
    chk("part_reserved_kept", int'(mem[19'(pix(100, 60, 10))]), 3);

    // Out of bounds in x
    mem[19'(225)] = 2'd2;
    run_req(225, 0);
    chk("oobx_err_cyc", err_cyc, 1);
    chk("oobx_nerr", n_err, 1);
    chk("oobx_nwr", wr_q.size(), 0);
    chk("oobx_neat", n_eat, 0);
    chk("oobx_rdy_cyc", rdy_cyc, 2);
    chk("oobx_dots", dots_at_rdy, 2);
    chk("oobx_mem_kept", int'(mem[19'(225)]), 2);

    // Out of bounds in y
    run_req(0, 141);
    chk("ooby_err_cyc", err_cyc, 1);
    chk("ooby_rdy_cyc", rdy_cyc, 2);

    // Last in-bounds corner (224,140): base 32144, last pixel 32831
    fill(224, 140, 2'd2);
    run_req(224, 140);
    chk("edge_nerr", n_err, 0);
    chk("edge_nwr", wr_q.size(), 16);
    chk("edge_first", wr_q[0], 32144);
    chk("edge_last", wr_q[15], 32831);
    chk("edge_dots", dots_at_rdy, 3);

    // Reset mid-scan: Reset sampled at edge t+8
    fill(30, 30, 2'd2);
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_x     = 9'd30;
    bus.req_y     = 9'd30;
    @(negedge Clk);
    bus.req_valid = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_we", int'(bus.ram_we), 0);
    chk("mid_ready", int'(bus.req_ready), 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_dots", int'(dots_eaten), 0);
    n_bad = 0;
    for (int i = 0; i < 7; i++) if (mem[19'(pix(30, 30, i))] != 2'd0) n_bad++;
    chk("mid_cleared_lost", n_bad, 0);
    n_bad = 0;
    for (int i = 7; i < 16; i++) if (mem[19'(pix(30, 30, i))] != 2'd2) n_bad++;
    chk("mid_untouched_lost", n_bad, 0);
    repeat (3) @(negedge Clk);
    chk("mid_still_idle", int'(bus.ram_we) + int'(busy), 0);

    // Saturation: 520 dots
    for (int k = 0; k < 520; k++) begin
      fill(0, 0, 2'd2);
      run_req(0, 0);
    end
    chk("sat_last_neat", n_eat, 1);
    chk("sat_dots", int'(dots_eaten), 511);
`ifdef DOT_ERASER_SCORE_EN
    chk("sat_score", int'(score), 5200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
